hex_ascii_parser: RTL and testbench

HEX_ASCII_PARSER -- requirements
Module: hex_ascii_parser

---
 rtl/hex_ascii_parser_if.sv | 24 ++
 rtl/hex_ascii_parser.sv | 93 +++++++++
 tb/tb_hex_ascii_parser.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hex_ascii_parser_if.sv
// hex_ascii_parser_if: byte-in / parsed-word-out stream bundle for hex_ascii_parser.
// master is the byte source plus result consumer; slave is the parser.
interface hex_ascii_parser_if #(
    parameter int MAX_DIGITS = 8
);
    logic [7:0]                          in_byte;
    logic                                in_valid;
    logic                                in_ready;
    logic [4*MAX_DIGITS-1:0]             out_word;
    logic [$clog2(MAX_DIGITS+1)-1:0]     out_digits;
    logic                                out_err;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_word, out_digits, out_err, out_valid
    );

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_word, out_digits, out_err, out_valid
    );
endinterface

// File: rtl/hex_ascii_parser.sv
// hex_ascii_parser: turns ASCII hex tokens ended by CR/LF/space into binary words.
// Define HEX_PARSER_LOWERCASE_EN to accept a-f as digits.
module hex_ascii_parser #(
    parameter int MAX_DIGITS = 8
) (
    input logic                clk,
    input logic                rst_n,
    hex_ascii_parser_if.slave  bus
);
    localparam int W  = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD, OUTPUT} state_t;

    state_t          state;
    logic [W-1:0]    acc;
    logic [CW-1:0]   count;
    logic            err;
    logic            is_num, is_up, is_lo, is_dig, is_term, take;
    logic [3:0]      dig;

    always_comb begin
        is_num  = bus.in_byte inside {[8'h30:8'h39]};
        is_up   = bus.in_byte inside {[8'h41:8'h46]};
`ifdef HEX_PARSER_LOWERCASE_EN
        is_lo   = bus.in_byte inside {[8'h61:8'h66]};
`else
        is_lo   = 1'b0;
`endif
        is_dig  = is_num | is_up | is_lo;
        is_term = bus.in_byte inside {8'h0D, 8'h0A, 8'h20};
        // 'A' and 'a' both have low nibble 1, so +9 maps the letters to 10-15
        dig     = is_num ? bus.in_byte[3:0] : bus.in_byte[3:0] + 4'd9;
        take    = bus.in_valid && bus.in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            acc            <= '0;
            count          <= '0;
            err            <= 1'b0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_word   <= '0;
            bus.out_digits <= '0;
            bus.out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    if (is_dig) begin
                        acc   <= W'(dig);
                        count <= CW'(1);
                        state <= ACCUM;
                    end else if (!is_term) begin
                        err   <= 1'b1;
                        state <= DISCARD;
                    end
                end
                ACCUM: if (take && !is_term) begin
                    if (is_dig && count != CW'(MAX_DIGITS)) begin
                        acc   <= (acc << 4) | W'(dig);
                        count <= count + 1'b1;
                    end else begin
                        err   <= 1'b1;
                        state <= DISCARD;
                    end
                end
                OUTPUT: if (bus.out_ready) begin
                    state          <= IDLE;
                    acc            <= '0;
                    count          <= '0;
                    err            <= 1'b0;
                    bus.in_ready   <= 1'b1;
                    bus.out_valid  <= 1'b0;
                    bus.out_word   <= '0;
                    bus.out_digits <= '0;
                    bus.out_err    <= 1'b0;
                end
                default: ;
            endcase
            // a terminator closes any open token (ACCUM or DISCARD); IDLE ignores it
            if (take && is_term && state != IDLE) begin
                state          <= OUTPUT;
                bus.in_ready   <= 1'b0;
                bus.out_valid  <= 1'b1;
                bus.out_word   <= err ? '0 : acc;
                bus.out_digits <= err ? '0 : count;
                bus.out_err    <= err;
            end
        end
    end
endmodule

// File: tb/tb_hex_ascii_parser.sv
// tb_hex_ascii_parser: directed and random token checks of hex_ascii_parser against a string-level model.
module tb_hex_ascii_parser;
`ifdef HEX_PARSER_LOWERCASE_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;

    hex_ascii_parser_if #(.MAX_DIGITS(8)) bus ();
    hex_ascii_parser #(.MAX_DIGITS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (LC && c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // result of one token (characters before its terminator)
    function automatic void model(input string tok, output logic [31:0] w,
                                  output logic [3:0] d, output logic e);
        int v;
        int n = 0;
        w = 0;
        e = 0;
        for (int i = 0; i < tok.len(); i++) begin
            v = hexval(tok[i]);
            if (v < 0) e = 1;
            else begin
                n++;
                w = w * 16 + 32'(v);
            end
        end
        if (n > 8) e = 1;
        d = e ? 4'd0 : 4'(n);
        if (e) w = 0;
    endfunction

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int n = 0;
            while (bus.in_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
            bus.in_byte  = s[i];
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_token(input string tag, input string s, input int stall,
                             input logic [31:0] ew, input logic [3:0] ed, input logic ee);
        bus.out_ready = (stall == 0);
        send(s);
        chk({tag, ".valid"},  32'(bus.out_valid),  32'd1);
        chk({tag, ".word"},   bus.out_word,        ew);
        chk({tag, ".digits"}, 32'(bus.out_digits), 32'(ed));
        chk({tag, ".err"},    32'(bus.out_err),    32'(ee));
        chk({tag, ".busy"},   32'(bus.in_ready),   32'd0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_word"},  bus.out_word,       ew);
            chk({tag, ".hold_busy"},  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".done"},  32'(bus.out_valid), 32'd0);
        chk({tag, ".ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, ".word"},   bus.out_word,        32'd0);
        chk({tag, ".digits"}, 32'(bus.out_digits), 32'd0);
        chk({tag, ".err"},    32'(bus.out_err),    32'd0);
    endtask

    initial begin
        string       tok, pre, alpha;
        string       terms [3];
        int          len, k, stall;
        logic [31:0] w;
        logic [3:0]  d;
        logic        e;

        terms = '{"\015", "\012", " "};
        alpha = "0123456789ABCDEFabcdefGx!z";
        bus.in_byte   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.ready", 32'(bus.in_ready), 32'd1);

        send("\015\012 ");
        chk("idle_term", 32'(bus.out_valid), 32'd0);

        run_token("r031", "1F\015", 0, 32'h1F, 4'd2, 1'b0);
        run_token("r032", "DEADBEEF ", 0, 32'hDEADBEEF, 4'd8, 1'b0);
        run_token("r033", "123456789\012", 0, 32'h0, 4'd0, 1'b1);
        run_token("r034a", "1G2\015", 0, 32'h0, 4'd0, 1'b1);
        run_token("r034b", "A\015", 0, 32'hA, 4'd1, 1'b0);
        run_token("r035", "ab\015", 0, LC ? 32'hAB : 32'h0, LC ? 4'd2 : 4'd0, !LC);
        run_token("r036a", "7\015", 5, 32'h7, 4'd1, 1'b0);
        run_token("zero", "0 ", 0, 32'h0, 4'd1, 1'b0);

        send("12");
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.ready", 32'(bus.in_ready), 32'd1);
        run_token("r036b", "3\015", 0, 32'h3, 4'd1, 1'b0);

        bus.out_ready = 1'b0;
        send("5\015");
        chk("rst_out.pending", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_out");
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out.ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out.dropped", 32'(bus.out_valid), 32'd0);
        run_token("after_rst", "4\015", 0, 32'h4, 4'd1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            tok = "";
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                k = ($urandom_range(0, 9) == 0) ? $urandom_range(22, 25) : $urandom_range(0, 21);
                tok = {tok, alpha.substr(k, k)};
            end
            pre = ($urandom_range(0, 3) == 0) ? " " : "";
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            model(tok, w, d, e);
            run_token($sformatf("rnd%0d", t), {pre, tok, terms[$urandom_range(0, 2)]}, stall, w, d, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
